// File: rtl/freq_pkg.sv
// Shared constants and helpers for the slow-tick divider slice.
package freq_pkg;

  localparam int unsigned SYS_CLK_HZ = 40_000_000;

  // A divide-by-1 half period still needs a 1-bit counter to elaborate cleanly.
  function automatic int unsigned cnt_width(input int unsigned half);
    return (half <= 1) ? 1 : $clog2(half);
  endfunction

endpackage

// File: rtl/freq_div_if.sv
// Tick outputs of freq_div bundled for the parking controller.
interface freq_div_if;
  logic clk_1Hz;
  logic clk_2Hz;

  modport master (output clk_1Hz, output clk_2Hz);
  modport slave  (input  clk_1Hz, input  clk_2Hz);
endinterface

// File: rtl/freq_div_toggle_div.sv
// Free-running counter that flips a registered level every HALF clock edges.
module toggle_div
  import freq_pkg::*;
#(
  parameter int unsigned HALF = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tog
);

  localparam int unsigned W    = cnt_width(HALF);
  localparam logic [W-1:0] LAST = W'(HALF - 1);

  logic [W-1:0] r_cnt;
  logic         r_tog;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_tog <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
      r_tog <= ~r_tog;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tog = r_tog;

endmodule

// File: rtl/freq_div.sv
// 1 Hz / 2 Hz 50%-duty level ticks derived from the system clock.
module freq_div
  import freq_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = SYS_CLK_HZ,
  parameter int unsigned SLOW_HZ     = 1,
  parameter int unsigned FAST_HZ     = 2
) (
  input  logic              clk,
  input  logic              reset,
  freq_div_if.master        o_tick
);

  localparam int unsigned HALF_SLOW = CLK_FREQ_HZ / (2 * SLOW_HZ);
  localparam int unsigned HALF_FAST = CLK_FREQ_HZ / (2 * FAST_HZ);

  if (CLK_FREQ_HZ % (2 * SLOW_HZ) != 0) begin : g_chk_slow_div
    $fatal(1, "freq_div: CLK_FREQ_HZ not divisible by 2*SLOW_HZ");
  end
  if (CLK_FREQ_HZ % (2 * FAST_HZ) != 0) begin : g_chk_fast_div
    $fatal(1, "freq_div: CLK_FREQ_HZ not divisible by 2*FAST_HZ");
  end
  if (HALF_SLOW < 1) begin : g_chk_slow_half
    $fatal(1, "freq_div: HALF_SLOW must be >= 1");
  end
  if (HALF_FAST < 1) begin : g_chk_fast_half
    $fatal(1, "freq_div: HALF_FAST must be >= 1");
  end

  logic w_tog_slow;
  logic w_tog_fast;

  toggle_div #(.HALF(HALF_SLOW)) u_slow (
    .clk   (clk),
    .reset (reset),
    .tog   (w_tog_slow)
  );

  toggle_div #(.HALF(HALF_FAST)) u_fast (
    .clk   (clk),
    .reset (reset),
    .tog   (w_tog_fast)
  );

  assign o_tick.clk_1Hz = w_tog_slow;
  assign o_tick.clk_2Hz = w_tog_fast;

endmodule

// File: tb/tb_freq_div.sv
// Directed bench for freq_div at default, 8 Hz and 4 Hz input clock settings.
module tb_freq_div;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  freq_div_if if_def ();
  freq_div_if if_d8 ();
  freq_div_if if_d4 ();

  freq_div u_def (
    .clk    (clk),
    .reset  (reset),
    .o_tick (if_def)
  );

  freq_div #(.CLK_FREQ_HZ(8)) u_d8 (
    .clk    (clk),
    .reset  (reset),
    .o_tick (if_d8)
  );

  freq_div #(.CLK_FREQ_HZ(4)) u_d4 (
    .clk    (clk),
    .reset  (reset),
    .o_tick (if_d4)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Level after k edges since reset release for a divider with half period h.
  function automatic logic wave(input int unsigned k, input int unsigned h);
    return ((k / h) % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input int unsigned k);
    chk($sformatf("d8_2Hz_k%0d", k), if_d8.clk_2Hz, wave(k, 2));
    chk($sformatf("d8_1Hz_k%0d", k), if_d8.clk_1Hz, wave(k, 4));
    chk($sformatf("d4_2Hz_k%0d", k), if_d4.clk_2Hz, wave(k, 1));
    chk($sformatf("d4_1Hz_k%0d", k), if_d4.clk_1Hz, wave(k, 2));
    chk($sformatf("def_2Hz_k%0d", k), if_def.clk_2Hz, 1'b0);
    chk($sformatf("def_1Hz_k%0d", k), if_def.clk_1Hz, 1'b0);
  endtask

  initial begin
    logic p8_2, p8_1, p4_2, p4_1;
    int   rise2, rise1, run2, run1;

    // Reset held for two edges.
    reset = 1'b1;
    tick();
    tick();
    chk("rst_def_2Hz", if_def.clk_2Hz, 1'b0);
    chk("rst_def_1Hz", if_def.clk_1Hz, 1'b0);
    chk("rst_d8_2Hz",  if_d8.clk_2Hz,  1'b0);
    chk("rst_d8_1Hz",  if_d8.clk_1Hz,  1'b0);
    chk("rst_d4_2Hz",  if_d4.clk_2Hz,  1'b0);
    chk("rst_d4_1Hz",  if_d4.clk_1Hz,  1'b0);

    // Free run for 64 edges: waveform, rising-edge counts, high-phase widths, phase.
    reset = 1'b0;
    p8_2 = 1'b0; p8_1 = 1'b0; p4_2 = 1'b0; p4_1 = 1'b0;
    rise2 = 0; rise1 = 0; run2 = 0; run1 = 0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      check_all(k);
      if (!p8_2 && if_d8.clk_2Hz) rise2++;
      if (!p8_1 && if_d8.clk_1Hz) rise1++;
      if (p8_2 && !if_d8.clk_2Hz) chk_int($sformatf("d8_2Hz_high_k%0d", k), run2, 2);
      if (p8_1 && !if_d8.clk_1Hz) chk_int($sformatf("d8_1Hz_high_k%0d", k), run1, 4);
      run2 = if_d8.clk_2Hz ? run2 + 1 : 0;
      run1 = if_d8.clk_1Hz ? run1 + 1 : 0;
      if (if_d4.clk_1Hz !== p4_1)
        chk($sformatf("d4_phase_k%0d", k), (if_d4.clk_2Hz !== p4_2), 1'b1);
      p8_2 = if_d8.clk_2Hz; p8_1 = if_d8.clk_1Hz;
      p4_2 = if_d4.clk_2Hz; p4_1 = if_d4.clk_1Hz;
    end
    chk_int("d8_2Hz_rises", rise2, 16);
    chk_int("d8_1Hz_rises", rise1, 8);

    // Fresh start, run until both 8 Hz outputs are high, then reset mid-phase.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_all(k);
    end
    chk("d8_2Hz_high_before_rst", if_d8.clk_2Hz, 1'b1);
    chk("d8_1Hz_high_before_rst", if_d8.clk_1Hz, 1'b1);
    reset = 1'b1;
    tick();
    chk("midrst_d8_2Hz", if_d8.clk_2Hz, 1'b0);
    chk("midrst_d8_1Hz", if_d8.clk_1Hz, 1'b0);
    chk("midrst_d4_2Hz", if_d4.clk_2Hz, 1'b0);
    chk("midrst_d4_1Hz", if_d4.clk_1Hz, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_all(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
